// File: rtl/cdec8_mem_arbiter.sv
// CDEC8 memory bus arbiter: the CPU owns the bus; host/debug accesses are slipped in by stalling the CPU.
// Optional ARB_STATS_EN adds grant/stall statistics counters readable on resdt.
//
// state    | meaning
// IDLE     | CPU owns bus, no host request pending
// WAIT_GAP | host pending, CPU still owns bus, searching for an idle cycle
// ACCESS   | host owns bus, strobe active for ACC_CYCLES clocks
// DONE     | host_ack pulse, strobes released
// HOLD     | decide between another burst access and returning the bus
module cdec8_mem_arbiter #(
    parameter int ACC_CYCLES     = 2,
    parameter int STARVE_LIMIT   = 64,
    parameter int HOST_BURST_MAX = 4
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic [7:0] cpu_adrs,
    input  logic [7:0] cpu_data_out,
    input  logic       cpu_mmrd_N,
    input  logic       cpu_mmwr_N,
    output logic       cpu_stall,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_adrs,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic [7:0] mem_adrs,
    output logic [7:0] mem_wdata,
    output logic       mem_rd_N,
    output logic       mem_wr_N,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] resad,
    output logic [7:0] resdt
);

    localparam logic [3:0] ACC_LAST    = 4'(ACC_CYCLES - 1);
    localparam logic [8:0] STARVE_LIM9 = 9'(STARVE_LIMIT);
    localparam logic [3:0] BURST_MAX4  = 4'(HOST_BURST_MAX);

    typedef enum logic [2:0] {IDLE, WAIT_GAP, ACCESS, DONE, HOLD} state_t;

    state_t     state, state_nxt;
    logic [3:0] acc_cnt, acc_cnt_nxt;
    logic [7:0] starve_cnt, starve_cnt_nxt;
    logic [3:0] burst_cnt, burst_cnt_nxt;
    logic       grant_now;
    logic       capture;
    logic       host_side;
    logic       cpu_idle;
    logic       starve_hit;

    assign cpu_idle   = cpu_mmrd_N & cpu_mmwr_N;
    assign starve_hit = ({1'b0, starve_cnt} + 9'd1) >= STARVE_LIM9;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state      <= IDLE;
            acc_cnt    <= 4'd0;
            starve_cnt <= 8'd0;
            burst_cnt  <= 4'd0;
            host_rdata <= 8'h00;
        end else begin
            state      <= state_nxt;
            acc_cnt    <= acc_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            burst_cnt  <= burst_cnt_nxt;
            if (capture)
                host_rdata <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt      = state;
        acc_cnt_nxt    = acc_cnt;
        starve_cnt_nxt = starve_cnt;
        burst_cnt_nxt  = burst_cnt;
        grant_now      = 1'b0;
        capture        = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_req) begin
                    state_nxt      = WAIT_GAP;
                    starve_cnt_nxt = 8'd0;
                end
            end
            WAIT_GAP: begin
                if (starve_cnt != 8'hFF)
                    starve_cnt_nxt = starve_cnt + 8'd1;
                if (cpu_idle || starve_hit) begin
                    state_nxt   = ACCESS;
                    acc_cnt_nxt = 4'd0;
                    grant_now   = 1'b1;
                end
            end
            ACCESS: begin
                if (acc_cnt >= ACC_LAST) begin
                    state_nxt = DONE;
                    capture   = ~host_we;
                end else begin
                    acc_cnt_nxt = acc_cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = HOLD;
                if (burst_cnt != 4'hF)
                    burst_cnt_nxt = burst_cnt + 4'd1;
            end
            HOLD: begin
                if (host_req && (burst_cnt < BURST_MAX4)) begin
                    state_nxt   = ACCESS;
                    acc_cnt_nxt = 4'd0;
                end else begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stall is raised in the grant cycle itself so the CPU does not advance
    // across the edge at which the bus changes hands.
    assign host_side = (state == ACCESS) || (state == DONE) || (state == HOLD);
    assign cpu_stall = host_side | grant_now;
    assign host_ack  = (state == DONE);

    assign mem_adrs  = host_side ? host_adrs  : cpu_adrs;
    assign mem_wdata = host_side ? host_wdata : cpu_data_out;
    assign mem_rd_N  = (state == ACCESS) ? host_we  : (host_side ? 1'b1 : cpu_mmrd_N);
    assign mem_wr_N  = (state == ACCESS) ? ~host_we : (host_side ? 1'b1 : cpu_mmwr_N);

`ifdef ARB_STATS_EN
    logic [15:0] host_grant_cnt;
    logic [15:0] stall_cycle_cnt;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            host_grant_cnt  <= 16'd0;
            stall_cycle_cnt <= 16'd0;
        end else begin
            if (host_ack && (host_grant_cnt != 16'hFFFF))
                host_grant_cnt <= host_grant_cnt + 16'd1;
            if (cpu_stall && (stall_cycle_cnt != 16'hFFFF))
                stall_cycle_cnt <= stall_cycle_cnt + 16'd1;
        end
    end

    assign resdt = (resad == 8'h0A) ? host_grant_cnt[15:8]  :
                   (resad == 8'h0B) ? host_grant_cnt[7:0]   :
                   (resad == 8'h0C) ? stall_cycle_cnt[15:8] :
                   (resad == 8'h0D) ? stall_cycle_cnt[7:0]  : 8'hZZ;
`else
    logic unused_resad;
    assign unused_resad = ^resad;
    assign resdt        = 8'hZZ;
`endif

endmodule

// File: tb/tb_cdec8_mem_arbiter.sv
// Directed bench for cdec8_mem_arbiter: single accesses from a vector table,
// then forced grant, burst exhaustion, async reset and (with ARB_STATS_EN) statistics.
module tb_cdec8_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset_N;
    logic [7:0] cpu_adrs, cpu_data_out;
    logic       cpu_mmrd_N, cpu_mmwr_N;
    logic       cpu_stall;
    logic       host_req, host_we;
    logic [7:0] host_adrs, host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic [7:0] mem_adrs, mem_wdata;
    logic       mem_rd_N, mem_wr_N;
    logic [7:0] mem_rdata;
    logic [7:0] resad;
    wire  [7:0] resdt;

    logic [7:0] mem_arr [256];

    int n_vec  = 0;
    int n_fail = 0;

    cdec8_mem_arbiter dut (
        .clock(clock), .reset_N(reset_N),
        .cpu_adrs(cpu_adrs), .cpu_data_out(cpu_data_out),
        .cpu_mmrd_N(cpu_mmrd_N), .cpu_mmwr_N(cpu_mmwr_N), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_adrs(host_adrs),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_adrs(mem_adrs), .mem_wdata(mem_wdata), .mem_rd_N(mem_rd_N),
        .mem_wr_N(mem_wr_N), .mem_rdata(mem_rdata), .resad(resad), .resdt(resdt)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem_arr[mem_adrs];
    always @(posedge clock)
        if (!mem_wr_N) mem_arr[mem_adrs] <= mem_wdata;

    typedef struct {
        logic       we;
        logic [7:0] adrs;
        logic [7:0] wdata;
        logic [7:0] cpu_a;
        logic [7:0] cpu_d;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One host transaction; called and returns just after a rising edge.
    // acc_at is the sample index of the first strobe cycle; the WAIT_GAP
    // entry edge lies between samples 1 and 2, so acc_at-2 is the number of
    // edges from WAIT_GAP entry to the grant edge.
    task automatic run_txn(input logic we, input logic [7:0] adrs, input logic [7:0] wdata,
                           output int n_stall, output int n_strobe, output int n_ack,
                           output int n_bad, output int stall_at, output int acc_at,
                           output logic [7:0] rd_at_ack, output logic tmo);
        int   cyc;
        logic seen, done;
        n_stall = 0; n_strobe = 0; n_ack = 0; n_bad = 0;
        stall_at = 0; acc_at = 0; rd_at_ack = 8'h00;
        cyc = 0; seen = 1'b0; done = 1'b0;
        host_we = we; host_adrs = adrs; host_wdata = wdata; host_req = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (cpu_stall) begin
                n_stall++;
                if (stall_at == 0) stall_at = cyc;
            end
            if (cpu_stall && (we ? !mem_wr_N : !mem_rd_N)) begin
                n_strobe++;
                if (acc_at == 0) acc_at = cyc;
                if (mem_adrs !== adrs || (we && mem_wdata !== wdata)) n_bad++;
            end
            if (host_ack) begin
                n_ack++;
                rd_at_ack = host_rdata;
                seen = 1'b1;
            end
            if (seen && !cpu_stall) done = 1'b1;
            @(posedge clock);
            #1;
            if (seen) host_req = 1'b0;
        end
        tmo = ~done;
        host_req = 1'b0;
    endtask

    int         ns, nst, na, nb, sat, aat;
    logic [7:0] rd;
    logic       tmo;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // we, adrs, wdata, cpu_a, cpu_d, exp_rdata (writes keep previous rdata)
        vecs[0] = '{1'b1, 8'h20, 8'h5A, 8'h11, 8'hC1, 8'h00};
        vecs[1] = '{1'b0, 8'h20, 8'h00, 8'h12, 8'hC2, 8'h5A};
        vecs[2] = '{1'b1, 8'h21, 8'hA5, 8'h13, 8'hC3, 8'h5A};
        vecs[3] = '{1'b0, 8'h21, 8'h00, 8'h14, 8'hC4, 8'hA5};
        vecs[4] = '{1'b0, 8'h20, 8'h00, 8'h15, 8'hC5, 8'h5A};
        vecs[5] = '{1'b1, 8'h20, 8'h00, 8'h16, 8'hC6, 8'h5A};
        vecs[6] = '{1'b0, 8'h20, 8'hFF, 8'h17, 8'hC7, 8'h00};

        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
        reset_N = 1'b0;
        cpu_adrs = 8'h3C; cpu_data_out = 8'h96; cpu_mmrd_N = 1'b1; cpu_mmwr_N = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_adrs = 8'h00; host_wdata = 8'h00;
        resad = 8'h00;

        repeat (2) @(negedge clock);
        chk("rst cpu_stall", 16'(cpu_stall), 16'd0);
        chk("rst host_ack", 16'(host_ack), 16'd0);
        chk("rst host_rdata", 16'(host_rdata), 16'h00);
        chk("rst mem_adrs", 16'(mem_adrs), 16'h3C);
        chk("rst mem_wdata", 16'(mem_wdata), 16'h96);
        @(posedge clock); #1;
        reset_N = 1'b1;
        @(posedge clock); #1;

        // Table: single accesses with the CPU idle.
        for (int i = 0; i < 7; i++) begin
            cpu_adrs = vecs[i].cpu_a; cpu_data_out = vecs[i].cpu_d;
            #1;
            chk($sformatf("v%0d pre mem_adrs", i), 16'(mem_adrs), 16'(vecs[i].cpu_a));
            run_txn(vecs[i].we, vecs[i].adrs, vecs[i].wdata, ns, nst, na, nb, sat, aat, rd, tmo);
            chk($sformatf("v%0d timeout", i), 16'(tmo), 16'd0);
            chk($sformatf("v%0d stall clocks", i), 16'(ns), 16'd5);
            chk($sformatf("v%0d strobe clocks", i), 16'(nst), 16'd2);
            chk($sformatf("v%0d ack pulses", i), 16'(na), 16'd1);
            chk($sformatf("v%0d bus adrs/data", i), 16'(nb), 16'd0);
            chk($sformatf("v%0d stall start", i), 16'(sat), 16'd2);
            chk($sformatf("v%0d grant delay", i), 16'(aat - 2), 16'd1);
            chk($sformatf("v%0d host_rdata", i), 16'(rd), 16'(vecs[i].exp_rdata));
            chk($sformatf("v%0d post mem_wdata", i), 16'(mem_wdata), 16'(vecs[i].cpu_d));
        end

        // Forced grant: CPU read strobe held active throughout.
        cpu_adrs = 8'h33; cpu_mmrd_N = 1'b0;
        run_txn(1'b1, 8'h40, 8'h77, ns, nst, na, nb, sat, aat, rd, tmo);
        chk("force timeout", 16'(tmo), 16'd0);
        chk("force grant delay", 16'(aat - 2), 16'd64);
        chk("force stall clocks", 16'(ns), 16'd5);
        chk("force strobe clocks", 16'(nst), 16'd2);
        chk("force bus adrs/data", 16'(nb), 16'd0);
        chk("force cpu rd resumes", 16'(mem_rd_N), 16'd0);
        chk("force cpu adrs resumes", 16'(mem_adrs), 16'h33);
        cpu_mmrd_N = 1'b1;
        @(posedge clock); #1;
        run_txn(1'b0, 8'h40, 8'h00, ns, nst, na, nb, sat, aat, rd, tmo);
        chk("force readback", 16'(rd), 16'h77);

        // Burst: six queued writes with host_req held.
        begin
            int   acks, cyc, wr_cyc, bad;
            int   zeros [6];
            logic got;
            acks = 0; cyc = 0; wr_cyc = 0; bad = 0;
            for (int k = 0; k < 6; k++) zeros[k] = 0;
            host_we = 1'b1; host_adrs = 8'h80; host_wdata = 8'h10; host_req = 1'b1;
            while (acks < 6 && cyc < 300) begin
                @(negedge clock);
                cyc++;
                if (cpu_stall && !mem_wr_N) begin
                    wr_cyc++;
                    if (mem_adrs !== 8'(8'h80 + acks) || mem_wdata !== 8'(8'h10 + acks)) bad++;
                end
                if (!cpu_stall && acks > 0) zeros[acks-1]++;
                got = host_ack;
                if (host_ack) acks++;
                @(posedge clock); #1;
                if (got) begin
                    if (acks < 6) begin
                        host_adrs = 8'(8'h80 + acks);
                        host_wdata = 8'(8'h10 + acks);
                    end else begin
                        host_req = 1'b0;
                    end
                end
            end
            host_req = 1'b0;
            chk("burst acks", 16'(acks), 16'd6);
            chk("burst write clocks", 16'(wr_cyc), 16'd12);
            chk("burst bus adrs/data", 16'(bad), 16'd0);
            chk("burst gap 1-2", 16'(zeros[0]), 16'd0);
            chk("burst gap 2-3", 16'(zeros[1]), 16'd0);
            chk("burst gap 3-4", 16'(zeros[2]), 16'd0);
            chk("burst gap 4-5 present", 16'(zeros[3] > 0), 16'd1);
            chk("burst gap 5-6", 16'(zeros[4]), 16'd0);
            cyc = 0;
            while (cpu_stall && cyc < 20) begin
                @(posedge clock); #1;
                cyc++;
            end
            chk("burst release", 16'(cpu_stall), 16'd0);
        end
        @(posedge clock); #1;
        run_txn(1'b0, 8'h85, 8'h00, ns, nst, na, nb, sat, aat, rd, tmo);
        chk("burst readback 85", 16'(rd), 16'h15);

        // Async reset in the middle of a host read.
        begin
            int cyc;
            cyc = 0;
            host_we = 1'b0; host_adrs = 8'h21; host_req = 1'b1;
            @(negedge clock);
            while (!(cpu_stall && !mem_rd_N) && cyc < 20) begin
                @(negedge clock);
                cyc++;
            end
            chk("rst-mid reached access", 16'(cpu_stall && !mem_rd_N), 16'd1);
            #2;
            reset_N = 1'b0;
            #1;
            chk("rst-mid mem_rd_N", 16'(mem_rd_N), 16'd1);
            chk("rst-mid mem_wr_N", 16'(mem_wr_N), 16'd1);
            chk("rst-mid cpu_stall", 16'(cpu_stall), 16'd0);
            chk("rst-mid host_ack", 16'(host_ack), 16'd0);
            chk("rst-mid host_rdata", 16'(host_rdata), 16'h00);
            host_req = 1'b0;
            @(posedge clock); #1;
            reset_N = 1'b1;
            @(posedge clock); #1;
            chk("rst-mid idle after", 16'(cpu_stall), 16'd0);
        end

        // Three single accesses after reset, feeding the statistics counters.
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b1, 8'(8'h90 + i), 8'(8'hE0 + i), ns, nst, na, nb, sat, aat, rd, tmo);
            chk($sformatf("stats txn%0d stall", i), 16'(ns), 16'd5);
        end
`ifdef ARB_STATS_EN
        resad = 8'h0B; #1;
        chk("stats grant lo", 16'(resdt), 16'h03);
        resad = 8'h0A; #1;
        chk("stats grant hi", 16'(resdt), 16'h00);
        resad = 8'h0D; #1;
        chk("stats stall lo", 16'(resdt), 16'h0F);
        resad = 8'h0C; #1;
        chk("stats stall hi", 16'(resdt), 16'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cdec8_mem_arbiter.md
Name: cdec8_mem_arbiter

Overview:
Shares the single 8-bit memory bus of the CDEC8 core between the CPU and a host/debug port (DE0 switch loader, monitor). The CPU owns the bus by default. Host accesses are slipped in by freezing the CPU through a clock-enable stall at a bus-idle cycle, or forcibly after a starvation limit. The block sits between CDEC8 and the memory array and owns the memory strobes.

Parameters:
ACC_CYCLES, 2, memory strobe width in clocks for one host access (1..15)
STARVE_LIMIT, 64, clocks a pending host request may wait for a CPU idle gap before a forced stall (1..255)
HOST_BURST_MAX, 4, maximum back-to-back host accesses per stall window (1..15)

Ports:
clock  in  1  system clock
reset_N  in  1  asynchronous active-low reset
cpu_adrs  in  8  CPU address
cpu_data_out  in  8  CPU write data
cpu_mmrd_N  in  1  CPU read strobe, active low
cpu_mmwr_N  in  1  CPU write strobe, active low
cpu_stall  out  1  high freezes CPU (gates its clock enable)
host_req  in  1  host request, level, held until host_ack
host_we  in  1  1=write, 0=read; valid with host_req
host_adrs  in  8  host address
host_wdata  in  8  host write data
host_ack  out  1  one-clock completion pulse
host_rdata  out  8  read data, valid from host_ack onward until next ack
mem_adrs  out  8  memory address
mem_wdata  out  8  memory write data
mem_rd_N  out  1  memory read strobe
mem_wr_N  out  1  memory write strobe
mem_rdata  in  8  memory read data
resad  in  8  resource/debug address (used only with option)
resdt  out  8  resource/debug data, 8'hZZ when not selected

Behaviour:
- Reset (async): state IDLE, cpu_stall=0, host_ack=0, host_rdata=8'h00, counters 0; memory bus muxed to CPU.
- Mux: in IDLE/WAIT_GAP the mem_* outputs pass CPU signals combinationally; in ACCESS/DONE/HOLD they carry host address/data with strobes from the FSM; CPU strobes are ignored (CPU is frozen).
- States: IDLE, WAIT_GAP, ACCESS, DONE, HOLD; all registered on posedge clock.
- IDLE: host_req=1 -> WAIT_GAP, starve count cleared.
- WAIT_GAP: starve count increments each clock. Go to ACCESS when cpu_mmrd_N=1 and cpu_mmwr_N=1 in that cycle, or when starve count reaches STARVE_LIMIT. cpu_stall rises at that same edge.
- ACCESS: exactly ACC_CYCLES clocks. mem_rd_N=~(~host_we) or mem_wr_N=~host_we is active low for the whole state. On the final ACCESS clock edge, mem_rdata is captured into host_rdata (reads only; writes leave it unchanged). Then go to DONE.
- DONE: 1 clock, host_ack=1, strobes inactive, cpu_stall=1, burst count +1. Then go to HOLD.
- HOLD: 1 clock, cpu_stall=1. If host_req=1 and burst count < HOST_BURST_MAX -> ACCESS (no new gap search). Otherwise burst count clears and state goes to IDLE with cpu_stall=0 at that edge.
- Host rule: host_req deasserts, or presents a new transaction, at the edge that ends DONE. host_req dropping before ack aborts nothing; the access completes and ack still pulses.
- Burst exhaustion: the CPU gets at least one unstalled clock (IDLE) before the next host grant.
- Counters saturate at their limits and never wrap.
- Reset mid-ACCESS releases the strobes and cpu_stall immediately.

Optional Feature:
ARB_STATS_EN: when defined, 16-bit saturating counters host_grant_cnt (+1 per DONE) and stall_cycle_cnt (+1 per clock with cpu_stall=1) are read on resdt at resad 8'h0A/8'h0B (grant hi/lo) and 8'h0C/8'h0D (stall hi/lo); reset clears them. When not defined, the counters are absent and resdt is a constant 8'hZZ.

Test Plan:
- Host write 8'h5A to 8'h20 while CPU is idle -> stall starts the next clock; mem_wr_N low for 2 clocks with mem_adrs=8'h20; host_ack 1 clock; stall lasts 5 clocks.
- Host read from 8'h20 after that write -> host_rdata=8'h5A at host_ack; CPU resumes with its strobes unchanged.
- CPU strobes held active continuously, host_req raised -> forced grant exactly 64 clocks after WAIT_GAP entry.
- host_req held with 6 queued transactions -> 4 accesses, then cpu_stall=0 for at least 1 clock, then the remaining 2.
- reset_N low during ACCESS -> mem_rd_N=mem_wr_N=1, cpu_stall=0, host_ack=0 asynchronously.
- ARB_STATS_EN defined, after 3 single accesses -> resad=8'h0B gives resdt=8'h03; resad=8'h0D gives 8'h0F; resad=8'h10 gives 8'hZZ.
